cfu_accum: RTL

CFU_ACCUM -- requirements
Module: cfu_accum

---
 rtl/cfu_accum_if.sv | 26 ++
 rtl/cfu_accum.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cfu_accum_if.sv
// cfu_accum_if -- command/response bus between a CPU custom-function port and
// the cfu_accum accelerator.
//   cmd_*  : command channel (valid/ready handshake, function id, two operands)
//   rsp_*  : response channel (valid/ready handshake, ok flag, result)
// master drives commands and consumes responses; slave is the accelerator side.
interface cfu_accum_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_function_id;
  logic [31:0] cmd_inputs_0;
  logic [31:0] cmd_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_response_ok;
  logic [31:0] rsp_outputs_0;

  modport master (
    output cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_response_ok, rsp_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_response_ok, rsp_outputs_0
  );
endinterface

// File: rtl/cfu_accum.sv
// cfu_accum -- byte-lane accumulator custom function unit.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : cfu_accum_if.slave command/response channel
// Functions: 0 CLEAR (return ACC, then zero it), 1 BYTESUM (ACC += Ak+Bk over
// four lanes), 2 SAD (ACC += |Ak-Bk| over four lanes), 3 READ, 4..7 illegal.
// SATURATE = 1 clamps ACC at all-ones on a per-lane carry instead of wrapping.
//
// state | meaning
// IDLE  | ready for a command
// BUSY  | one byte lane added per cycle, LANE selects the lane
// RESP  | response held on the bus until rsp_ready
module cfu_accum #(
  parameter bit SATURATE = 1'b0
) (
  input logic        clk,
  input logic        rst,
  cfu_accum_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] acc, acc_nxt;
  logic [31:0] res, res_nxt;
  logic        ok, ok_nxt;
  logic [1:0]  lane, lane_nxt;
  logic [2:0]  fid, fid_nxt;
  logic [31:0] op_a, op_a_nxt;
  logic [31:0] op_b, op_b_nxt;

  logic [7:0]  a_byte, b_byte;
  logic [8:0]  lane_term;
  logic [32:0] lane_sum;
  logic [31:0] lane_acc;

  // Per-lane contribution from the latched operands.
  always_comb begin
    a_byte = op_a[{lane, 3'b000} +: 8];
    b_byte = op_b[{lane, 3'b000} +: 8];
    if (fid == 3'd2) begin
      lane_term = (a_byte >= b_byte) ? {1'b0, a_byte - b_byte} : {1'b0, b_byte - a_byte};
    end else begin
      lane_term = {1'b0, a_byte} + {1'b0, b_byte};
    end
    lane_sum = {1'b0, acc} + {24'b0, lane_term};
    // A carry out clamps; once at all-ones any further lane carries again.
    lane_acc = (SATURATE && lane_sum[32]) ? 32'hFFFF_FFFF : lane_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      res   <= '0;
      ok    <= 1'b0;
      lane  <= '0;
      fid   <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      res   <= res_nxt;
      ok    <= ok_nxt;
      lane  <= lane_nxt;
      fid   <= fid_nxt;
      op_a  <= op_a_nxt;
      op_b  <= op_b_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    res_nxt   = res;
    ok_nxt    = ok;
    lane_nxt  = lane;
    fid_nxt   = fid;
    op_a_nxt  = op_a;
    op_b_nxt  = op_b;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          fid_nxt  = bus.cmd_function_id;
          op_a_nxt = bus.cmd_inputs_0;
          op_b_nxt = bus.cmd_inputs_1;
          case (bus.cmd_function_id)
            3'd0: begin
              res_nxt   = acc;
              ok_nxt    = 1'b1;
              acc_nxt   = '0;
              state_nxt = RESP;
            end
            3'd1, 3'd2: begin
              lane_nxt  = '0;
              state_nxt = BUSY;
            end
            3'd3: begin
              res_nxt   = acc;
              ok_nxt    = 1'b1;
              state_nxt = RESP;
            end
            default: begin
              res_nxt   = '0;
              ok_nxt    = 1'b0;
              state_nxt = RESP;
            end
          endcase
        end
      end
      BUSY: begin
        acc_nxt  = lane_acc;
        lane_nxt = lane + 2'd1;
        if (lane == 2'd3) begin
          res_nxt   = lane_acc;
          ok_nxt    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cmd_ready       = (state == IDLE);
  assign bus.rsp_valid       = (state == RESP);
  assign bus.rsp_response_ok = (state == RESP) ? ok : 1'b0;
  assign bus.rsp_outputs_0   = (state == RESP) ? res : 32'h0;

endmodule
